fetch_pc_unit: RTL and testbench

//  Program-counter / fetch-control stage feeding the instruction memory (pc_mem).

---
 rtl/fetch_pc_unit_if.sv | 43 ++++
 rtl/fetch_pc_unit.sv | 106 ++++++++++
 tb/tb_fetch_pc_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard/branch/halt controls into the PC unit, pc_mem controls
// and the {if_pc, if_valid} tag out of it.
//
// Handshake: there is no valid/ready pair on this bus. Every control input is a
// level that is sampled on each rising clock edge. redirect_valid qualifies
// redirect_target in the same cycle. if_valid qualifies if_pc, and the word that
// pc_mem presents on read_data, in the same cycle. The consumer cannot apply
// back-pressure except through stall.
interface fetch_pc_unit_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int CNT_WIDTH  = 32
);
  // control inputs to the PC unit
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  halt_req;
  logic                  resume;
  // pc_mem controls and fetch tag driven by the PC unit
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_flush;
  logic                  imem_stall;
  logic                  imem_halted;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_valid;
  logic [CNT_WIDTH-1:0]  fetch_count;
  // debug view of the run/halt state (1 = HALTED)
  logic                  dbg_state;

  // The PC unit drives the instruction-memory side.
  modport master (
    input  stall, redirect_valid, redirect_target, halt_req, resume,
    output imem_addr, imem_flush, imem_stall, imem_halted,
    output if_pc, if_valid, fetch_count, dbg_state
  );

  // The pipeline and environment drive the controls and observe the fetch side.
  modport slave (
    output stall, redirect_valid, redirect_target, halt_req, resume,
    input  imem_addr, imem_flush, imem_stall, imem_halted,
    input  if_pc, if_valid, fetch_count, dbg_state
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter and fetch-control stage for pc_mem. It holds the PC, issues
// the flush/stall/halted controls, and tags the word on read_data with its PC
// and a valid bit. It also handles branch redirect, halt/resume and a saturating
// fetch counter.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           reset,   // asynchronous, active-low
  fetch_pc_unit_if.master bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic run;
  logic flush;
  logic fire;

  // Decode the current cycle. In HALTED the controls are ignored and no flush is
  // issued. The flush and stall outputs are forced low while reset is asserted,
  // so pc_mem sees idle controls during reset.
  always_comb begin
    run   = (state_q == ST_RUN);
    flush = reset & bus.redirect_valid & run;
    fire  = run & ~bus.stall & ~bus.redirect_valid & ~bus.halt_req;
  end

  // Next-state logic. In RUN the priority is redirect > halt > stall > fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;
    case (state_q)
      ST_RUN: begin
        if (bus.redirect_valid) begin
          // The flush kills the in-flight word, so the next cycle is a bubble.
          pc_d       = bus.redirect_target;
          if_valid_d = 1'b0;
          if (bus.halt_req) state_d = ST_HALTED;
        end else if (bus.halt_req) begin
          state_d    = ST_HALTED;
          if_valid_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything. pc_mem keeps read_data stable under imem_stall.
        end else if (fire) begin
          pc_d       = pc_q + 1'b1;        // wraps modulo 2**ADDR_WIDTH
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (count_q != {CNT_WIDTH{1'b1}}) count_d = count_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if_valid_d = 1'b0;
        // After resume, the held PC is fetched on the following edge if fire is set.
        if (bus.resume) state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_RUN;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State registers. An asynchronous reset discards any pending redirect or halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

  // Output assignments.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.imem_flush  = flush;
    bus.imem_stall  = reset & bus.stall & ~flush;
    bus.imem_halted = (state_q == ST_HALTED);
    bus.if_pc       = if_pc_q;
    bus.if_valid    = if_valid_q;
    bus.fetch_count = count_q;
    bus.dbg_state   = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. dut is the default build (RESET_PC=0).
// dut_w runs idle next to it with RESET_PC=8190 and a 2-bit counter, which
// exercises PC wrap and counter saturation.
module tb_fetch_pc_unit;

  localparam int AW = 13;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_pc_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(32)) bus   ();
  fetch_pc_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(2))  bus_w ();

  fetch_pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(13'd0), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(13'd8190), .CNT_WIDTH(2)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [AW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then move clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.halt_req        = 1'b0;
    bus.resume          = 1'b0;
  endtask

  task automatic check_main(input string tag, input logic [AW-1:0] addr,
                            input logic [AW-1:0] ipc, input logic vld, input logic [31:0] cnt);
    check_eq({tag, ".addr"},  32'(bus.imem_addr),  32'(addr));
    check_eq({tag, ".if_pc"}, 32'(bus.if_pc),      32'(ipc));
    check_eq({tag, ".valid"}, 32'(bus.if_valid),   32'(vld));
    check_eq({tag, ".count"}, bus.fetch_count,     cnt);
  endtask

  // Hand-computed values for the RESET_PC=8190 / 2-bit counter instance.
  logic [AW-1:0] w_addr [4];
  logic [AW-1:0] w_ifpc [4];
  logic [1:0]    w_cnt  [4];

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    w_addr = '{13'd8191, 13'd0,    13'd1, 13'd2};
    w_ifpc = '{13'd8190, 13'd8191, 13'd0, 13'd1};
    w_cnt  = '{2'd1,     2'd2,     2'd3,  2'd3};

    reset = 1'b0;
    idle_inputs();
    bus_w.stall           = 1'b0;
    bus_w.redirect_valid  = 1'b0;
    bus_w.redirect_target = '0;
    bus_w.halt_req        = 1'b0;
    bus_w.resume          = 1'b0;
    #12 reset = 1'b1;
    #1;

    // Reset state
    check_main("rst", 13'd0, 13'd0, 1'b0, 32'd0);
    check_eq("rst.flush",  32'(bus.imem_flush),  32'd0);
    check_eq("rst.stall",  32'(bus.imem_stall),  32'd0);
    check_eq("rst.halted", 32'(bus.imem_halted), 32'd0);
    check_eq("rst_w.addr", 32'(bus_w.imem_addr), 32'd8190);

    // T1 / T5: free run for 4 edges
    for (int k = 0; k < 4; k++) exp_q.push_back(AW'(k));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_main($sformatf("t1.%0d", k), AW'(k), exp_q.pop_front(), 1'b1, 32'(k));
      check_eq($sformatf("t5.addr%0d", k),  32'(bus_w.imem_addr),   32'(w_addr[k-1]));
      check_eq($sformatf("t5.ifpc%0d", k),  32'(bus_w.if_pc),       32'(w_ifpc[k-1]));
      check_eq($sformatf("t5.cnt%0d", k),   32'(bus_w.fetch_count), 32'(w_cnt[k-1]));
    end

    // T2: reach pc=5, then stall for 3 cycles
    tick();
    check_main("t2.pre", 13'd5, 13'd4, 1'b1, 32'd5);
    bus.stall = 1'b1;
    #1;
    check_eq("t2.imem_stall", 32'(bus.imem_stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_main($sformatf("t2.hold%0d", k), 13'd5, 13'd4, 1'b1, 32'd5);
    end
    bus.stall = 1'b0;
    tick();
    check_main("t2.rel", 13'd6, 13'd5, 1'b1, 32'd6);
    check_eq("t5.sat", 32'(bus_w.fetch_count), 32'd3);

    // T3: redirect at pc=9 while stalled
    tick(); tick(); tick();
    check_main("t3.pre", 13'd9, 13'd8, 1'b1, 32'd9);
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 13'h100;
    #1;
    check_eq("t3.flush",      32'(bus.imem_flush), 32'd1);
    check_eq("t3.stall_mask", 32'(bus.imem_stall), 32'd0);
    tick();
    idle_inputs();
    #1;
    check_main("t3.bubble", 13'h100, 13'd8, 1'b0, 32'd9);
    check_eq("t3.flush_off", 32'(bus.imem_flush), 32'd0);
    tick();
    check_main("t3.target", 13'h101, 13'h100, 1'b1, 32'd10);

    // T4: move to pc=20, halt, ignore redirect/stall, then resume
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 13'd20;
    tick();
    idle_inputs();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    #1;
    check_eq("t4.halted", 32'(bus.imem_halted), 32'd1);
    check_eq("t4.dbg",    32'(bus.dbg_state),   32'd1);
    for (int k = 0; k < 10; k++) begin
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 13'h55;
      bus.stall           = k[0];
      bus.halt_req        = k[1];
      #1;
      check_eq($sformatf("t4.noflush%0d", k), 32'(bus.imem_flush), 32'd0);
      tick();
      check_main($sformatf("t4.hold%0d", k), 13'd20, 13'h100, 1'b0, 32'd10);
      check_eq($sformatf("t4.h%0d", k), 32'(bus.imem_halted), 32'd1);
    end
    idle_inputs();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1;
    check_eq("t4.run", 32'(bus.imem_halted), 32'd0);
    check_main("t4.res0", 13'd20, 13'h100, 1'b0, 32'd10);
    tick();
    check_main("t4.res1", 13'd21, 13'd20, 1'b1, 32'd11);

    // T6a: reset asserted while a redirect is being presented
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 13'h77;
    bus.stall           = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_main("t6a", 13'd0, 13'd0, 1'b0, 32'd0);
    check_eq("t6a.flush",  32'(bus.imem_flush),  32'd0);
    check_eq("t6a.stall",  32'(bus.imem_stall),  32'd0);
    check_eq("t6a.halted", 32'(bus.imem_halted), 32'd0);
    check_eq("t6a.w_addr", 32'(bus_w.imem_addr), 32'd8190);
    idle_inputs();
    #2 reset = 1'b1;
    tick();
    check_main("t6a.run1", 13'd1, 13'd0, 1'b1, 32'd1);
    tick();
    bus.halt_req = 1'b1;
    tick();
    #1;
    check_eq("t6b.pre_halted", 32'(bus.imem_halted), 32'd1);
    check_eq("t6b.pre_addr",   32'(bus.imem_addr),   32'd2);

    // T6b: reset asserted while HALTED
    reset = 1'b0;
    #1;
    check_eq("t6b.halted", 32'(bus.imem_halted), 32'd0);
    check_main("t6b", 13'd0, 13'd0, 1'b0, 32'd0);
    bus.halt_req = 1'b0;
    #1 reset = 1'b1;
    tick();
    check_main("t6b.run1", 13'd1, 13'd0, 1'b1, 32'd1);
    check_eq("t6b.halted_after", 32'(bus.imem_halted), 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
